// File: rtl/ball_ctrl.sv
// Pong game logic: advances the ball once per frame, bounces it off walls and paddles,
// keeps score and sequences serve / play / scored / game-over.
module ball_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 4,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_L_X   = 16,
  parameter int PADDLE_R_X   = 616,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  input  logic [19:0] ppos,
  output logic [19:0] ball,
  output logic [7:0]  score,
  output logic        play_active,
  output logic        game_over
);

  localparam int CNT_W = $clog2(SERVE_FRAMES);

  localparam logic [9:0] CTR_X = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] CTR_Y = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [3:0] WIN   = 4'(WIN_SCORE);

  localparam logic signed [11:0] SPD    = 12'(BALL_SPEED);
  localparam logic signed [11:0] BSZ    = 12'(BALL_SIZE);
  localparam logic signed [11:0] PH     = 12'(PADDLE_H);
  localparam logic signed [11:0] X_MAX  = 12'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [11:0] Y_MAX  = 12'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [11:0] L_X    = 12'(PADDLE_L_X);
  localparam logic signed [11:0] L_FACE = 12'(PADDLE_L_X + PADDLE_W);
  localparam logic signed [11:0] R_X    = 12'(PADDLE_R_X);
  localparam logic signed [11:0] R_BACK = 12'(PADDLE_R_X + PADDLE_W);

  typedef enum logic [1:0] {SERVE, PLAY, SCORED, GAMEOVER} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [9:0]       ball_x, ball_x_n, ball_y, ball_y_n;
  logic             vx_neg, vx_neg_n, vy_neg, vy_neg_n;
  logic [3:0]       p1score, p1score_n, p2score, p2score_n;
  logic             p1_lost, p1_lost_n;

  logic                tick;
  logic signed [11:0]  nx, ny, p1_top, p2_top;
  logic                hit_l, hit_r;

  assign tick = (hcnt == 10'd0) && (vcnt == 10'(V_ACTIVE));

  // Candidate position and paddle contact tests; 12-bit signed so an edge overshoot stays negative.
  assign nx     = $signed({2'b00, ball_x}) + (vx_neg ? -SPD : SPD);
  assign ny     = $signed({2'b00, ball_y}) + (vy_neg ? -SPD : SPD);
  assign p1_top = $signed({2'b00, ppos[9:0]});
  assign p2_top = $signed({2'b00, ppos[19:10]});
  assign hit_l  = vx_neg && (nx <= L_FACE) && (nx + BSZ > L_X)
                  && (ny + BSZ > p1_top) && (ny < p1_top + PH);
  assign hit_r  = !vx_neg && (nx + BSZ >= R_X) && (nx < R_BACK)
                  && (ny + BSZ > p2_top) && (ny < p2_top + PH);

  // NOTE: every next-state variable is defaulted first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ball_x_n  = ball_x;
    ball_y_n  = ball_y;
    vx_neg_n  = vx_neg;
    vy_neg_n  = vy_neg;
    p1score_n = p1score;
    p2score_n = p2score;
    p1_lost_n = p1_lost;
    if (tick) begin
      unique case (state)
        SERVE: begin
          if (cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            state_n = PLAY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        PLAY: begin
          ball_y_n = ny[9:0];
          if (ny < 12'sd0) begin
            ball_y_n = '0;
            vy_neg_n = 1'b0;
          end else if (ny > Y_MAX) begin
            ball_y_n = Y_MAX[9:0];
            vy_neg_n = 1'b1;
          end
          // A missed ball keeps its x; only y follows the wall rule on that tick.
          if (hit_l) begin
            ball_x_n = L_FACE[9:0];
            vx_neg_n = 1'b0;
          end else if (hit_r) begin
            ball_x_n = 10'(PADDLE_R_X - BALL_SIZE);
            vx_neg_n = 1'b1;
          end else if (nx < 12'sd0) begin
            if (p2score != WIN) p2score_n = p2score + 1'b1;
            p1_lost_n = 1'b1;
            state_n   = SCORED;
          end else if (nx > X_MAX) begin
            if (p1score != WIN) p1score_n = p1score + 1'b1;
            p1_lost_n = 1'b0;
            state_n   = SCORED;
          end else begin
            ball_x_n = nx[9:0];
          end
        end
        SCORED: begin
          if (p1score == WIN || p2score == WIN) begin
            state_n = GAMEOVER;
          end else begin
            ball_x_n = CTR_X;
            ball_y_n = CTR_Y;
            vx_neg_n = p1_lost;
            state_n  = SERVE;
          end
        end
        GAMEOVER: ;
        default: state_n = SERVE;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= SERVE;
      cnt     <= '0;
      ball_x  <= CTR_X;
      ball_y  <= CTR_Y;
      vx_neg  <= 1'b0;
      vy_neg  <= 1'b0;
      p1score <= '0;
      p2score <= '0;
      p1_lost <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ball_x  <= ball_x_n;
      ball_y  <= ball_y_n;
      vx_neg  <= vx_neg_n;
      vy_neg  <= vy_neg_n;
      p1score <= p1score_n;
      p2score <= p2score_n;
      p1_lost <= p1_lost_n;
    end
  end

  assign ball        = {ball_x, ball_y};
  assign score       = {p2score, p1score};
  assign play_active = (state == PLAY);
  assign game_over   = (state == GAMEOVER);

endmodule
